// File: rtl/uart_cmd_sequencer.sv
// UART debugger command sequencer: parses W/R/P packets from the receiver,
// issues one memory transaction per packet and streams the response bytes out.
module uart_cmd_sequencer #(
    parameter int ADDR_BYTES     = 2,
    parameter int DATA_BYTES     = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rx_valid_in,
    input  logic [7:0]                rx_byte_in,
    output logic                      mem_req_out,
    output logic                      mem_we_out,
    output logic [8*ADDR_BYTES-1:0]   mem_addr_out,
    output logic [8*DATA_BYTES-1:0]   mem_wdata_out,
    input  logic                      mem_ack_in,
    input  logic [8*DATA_BYTES-1:0]   mem_rdata_in,
    output logic                      tx_valid_out,
    output logic [7:0]                tx_byte_out,
    input  logic                      tx_ready_in,
    output logic                      busy_out,
    output logic                      timeout_err_out,
    output logic                      overrun_out
);

    localparam int AW   = 8 * ADDR_BYTES;
    localparam int DW   = 8 * DATA_BYTES;
    localparam int MAXB = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
    localparam int CW   = $clog2(MAXB + 1);
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_BYTES - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BYTES - 1);
    localparam logic [CW-1:0] LEN_ONE   = CW'(1);
    localparam logic [CW-1:0] LEN_DATA  = CW'(DATA_BYTES);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_PING  = 8'h50;

    // Single-byte responses sit in the MSB lane so the shifter emits them first.
    localparam logic [DW-1:0] RESP_OK  = DW'(8'h4B) << (DW - 8);
    localparam logic [DW-1:0] RESP_BAD = DW'(8'h3F) << (DW - 8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_MEM,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   resp_len_q, resp_len_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            is_wr_q, is_wr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   resp_q, resp_d;
    logic            tmo_err_q, tmo_err_d;
    logic            overrun_q, overrun_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        resp_len_d = resp_len_q;
        tmo_d      = tmo_q;
        is_wr_d    = is_wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        resp_d     = resp_q;
        tmo_err_d  = 1'b0;
        overrun_d  = overrun_q;

        case (state_q)
            S_IDLE: begin
                if (rx_valid_in) begin
                    cnt_d = '0;
                    tmo_d = '0;
                    if (rx_byte_in == OP_WRITE || rx_byte_in == OP_READ) begin
                        is_wr_d = (rx_byte_in == OP_WRITE);
                        state_d = S_ADDR;
                    end else begin
                        resp_d     = (rx_byte_in == OP_PING) ? RESP_OK : RESP_BAD;
                        resp_len_d = LEN_ONE;
                        state_d    = S_RESP;
                    end
                end
            end
            S_ADDR, S_DATA: begin
                // An arriving byte always wins over an expiring timeout.
                if (rx_valid_in) begin
                    tmo_d = '0;
                    if (state_q == S_ADDR) begin
                        addr_d = (addr_q << 8) | AW'(rx_byte_in);
                        if (cnt_q == ADDR_LAST) begin
                            cnt_d   = '0;
                            state_d = is_wr_q ? S_DATA : S_MEM;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        wdata_d = (wdata_q << 8) | DW'(rx_byte_in);
                        if (cnt_q == DATA_LAST) begin
                            cnt_d   = '0;
                            state_d = S_MEM;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d     = '0;
                    cnt_d     = '0;
                    tmo_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_MEM: begin
                if (rx_valid_in) begin
                    overrun_d = 1'b1;
                end
                if (mem_ack_in) begin
                    cnt_d      = '0;
                    resp_d     = is_wr_q ? RESP_OK : mem_rdata_in;
                    resp_len_d = is_wr_q ? LEN_ONE : LEN_DATA;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                if (rx_valid_in) begin
                    overrun_d = 1'b1;
                end
                if (tx_ready_in) begin
                    resp_d = resp_q << 8;
                    if (cnt_q + CW'(1) == resp_len_q) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            resp_len_q <= '0;
            tmo_q      <= '0;
            is_wr_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_q     <= '0;
            tmo_err_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            resp_len_q <= resp_len_d;
            tmo_q      <= tmo_d;
            is_wr_q    <= is_wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            resp_q     <= resp_d;
            tmo_err_q  <= tmo_err_d;
            overrun_q  <= overrun_d;
        end
    end

    assign mem_req_out     = (state_q == S_MEM);
    assign mem_we_out      = (state_q == S_MEM) && is_wr_q;
    assign mem_addr_out    = addr_q;
    assign mem_wdata_out   = wdata_q;
    assign tx_valid_out    = (state_q == S_RESP);
    assign tx_byte_out     = resp_q[DW-1 -: 8];
    assign busy_out        = (state_q != S_IDLE);
    assign timeout_err_out = tmo_err_q;
    assign overrun_out     = overrun_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Bench for uart_cmd_sequencer: vector table plus corner-case sequences,
// with scoreboards for memory transactions and transmitted bytes.
module tb_uart_cmd_sequencer;

    localparam int T = 20;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        rx_valid_in;
    logic [7:0]  rx_byte_in;
    logic        mem_req_out, mem_we_out;
    logic [15:0] mem_addr_out;
    logic [31:0] mem_wdata_out;
    logic        mem_ack_in;
    logic [31:0] mem_rdata_in;
    logic        tx_valid_out;
    logic [7:0]  tx_byte_out;
    logic        tx_ready_in;
    logic        busy_out, timeout_err_out, overrun_out;

    always #5 clk = ~clk;

    uart_cmd_sequencer #(.ADDR_BYTES(2), .DATA_BYTES(4), .TIMEOUT_CYCLES(T)) dut (
        .clk_in(clk), .rst_in(rst_in), .rx_valid_in(rx_valid_in), .rx_byte_in(rx_byte_in),
        .mem_req_out(mem_req_out), .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out),
        .mem_wdata_out(mem_wdata_out), .mem_ack_in(mem_ack_in), .mem_rdata_in(mem_rdata_in),
        .tx_valid_out(tx_valid_out), .tx_byte_out(tx_byte_out), .tx_ready_in(tx_ready_in),
        .busy_out(busy_out), .timeout_err_out(timeout_err_out), .overrun_out(overrun_out)
    );

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct {
        logic [7:0]  op;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_dly;
        int          stall;
        int          gap;
        int          n_resp;
        logic [31:0] resp;
        logic        mem;
    } vec_t;

    mem_exp_t    mem_q[$];
    logic [7:0]  tx_q[$];
    int          checks = 0;
    int          errors = 0;
    int          tmo_count = 0;
    int          ack_delay = 0;
    int          ready_stall = 0;
    logic [31:0] rd_value = 32'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: acks after ack_delay request cycles.
    initial begin
        int req_wait;
        req_wait = 0;
        mem_ack_in = 1'b0;
        mem_rdata_in = 32'h0;
        forever begin
            step();
            mem_ack_in = 1'b0;
            if (rst_in && mem_req_out) begin
                if (req_wait >= ack_delay) begin
                    mem_ack_in = 1'b1;
                    mem_rdata_in = rd_value;
                    req_wait = 0;
                end else begin
                    req_wait++;
                end
            end else begin
                req_wait = 0;
            end
        end
    end

    // Transmitter model: holds ready low for ready_stall cycles per byte.
    initial begin
        int stall;
        stall = 0;
        tx_ready_in = 1'b0;
        forever begin
            step();
            tx_ready_in = 1'b0;
            if (rst_in && tx_valid_out) begin
                if (stall >= ready_stall) begin
                    tx_ready_in = 1'b1;
                    stall = 0;
                end else begin
                    stall++;
                end
            end else begin
                stall = 0;
            end
        end
    end

    // Scoreboard monitors.
    logic       ack_seen = 1'b0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_byte = 8'h0;
    always @(negedge clk) begin
        if (!rst_in) begin
            ack_seen = 1'b0;
            prev_hold = 1'b0;
        end else begin
            if (ack_seen) check("mem_req_fall", 64'(mem_req_out), 64'(0));
            ack_seen = 1'b0;
            if (mem_req_out) begin
                if (mem_q.size() == 0) begin
                    check("mem_unexpected_req", 64'(mem_req_out), 64'(0));
                end else begin
                    check("mem_we", 64'(mem_we_out), 64'(mem_q[0].we));
                    check("mem_addr", 64'(mem_addr_out), 64'(mem_q[0].addr));
                    if (mem_q[0].we) check("mem_wdata", 64'(mem_wdata_out), 64'(mem_q[0].wdata));
                    if (mem_ack_in) begin
                        void'(mem_q.pop_front());
                        ack_seen = 1'b1;
                    end
                end
            end
            if (prev_hold) check("tx_stable", 64'({tx_valid_out, tx_byte_out}), 64'({1'b1, prev_byte}));
            prev_hold = tx_valid_out && !tx_ready_in;
            prev_byte = tx_byte_out;
            if (tx_valid_out && tx_ready_in) begin
                if (tx_q.size() == 0) check("tx_unexpected", 64'(tx_valid_out), 64'(0));
                else check("tx_byte", 64'(tx_byte_out), 64'(tx_q.pop_front()));
            end
            if (timeout_err_out) tmo_count++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_valid_in = 1'b1;
        rx_byte_in = b;
        step();
        rx_valid_in = 1'b0;
    endtask

    task automatic send_packet(input logic [7:0] op, input logic [15:0] addr,
                               input logic [31:0] wdata, input int gap);
        send_byte(op);
        if (op == 8'h57 || op == 8'h52) begin
            for (int i = 0; i < 2; i++) begin
                repeat (gap) step();
                send_byte(addr[15 - 8*i -: 8]);
            end
            if (op == 8'h57) begin
                for (int i = 0; i < 4; i++) begin
                    repeat (gap) step();
                    send_byte(wdata[31 - 8*i -: 8]);
                end
            end
        end
    endtask

    task automatic push_mem(input logic we, input logic [15:0] addr, input logic [31:0] wdata);
        mem_exp_t e;
        e.we = we;
        e.addr = addr;
        e.wdata = wdata;
        mem_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy_out || tx_q.size() != 0) && n < 300) begin
            step();
            n++;
        end
        check({name, " busy"}, 64'(busy_out), 64'(0));
        check({name, " tx_pending"}, 64'(tx_q.size()), 64'(0));
        check({name, " mem_pending"}, 64'(mem_q.size()), 64'(0));
    endtask

    task automatic check_zero(input string name);
        check({name, " outputs"}, 64'({mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out,
              tx_valid_out, tx_byte_out, busy_out, timeout_err_out, overrun_out}), 64'(0));
    endtask

    task automatic do_reset(input string name);
        #2 rst_in = 1'b0;
        #1 check_zero(name);
        step();
        mem_q.delete();
        tx_q.delete();
        #2 rst_in = 1'b1;
        step();
    endtask

    task automatic ping(input string name);
        ack_delay = 0;
        ready_stall = 0;
        tx_q.push_back(8'h4B);
        send_byte(8'h50);
        check({name, " ping_valid"}, 64'(tx_valid_out), 64'(1));
        wait_idle(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[8];
    int   base;

    initial begin
        vecs[0] = '{8'h57, 16'h1234, 32'hDEADBEEF, 32'h0,        3, 0, 0,  1, 32'h4B000000, 1'b1};
        vecs[1] = '{8'h52, 16'h0010, 32'h0,        32'hCAFEF00D, 2, 5, 0,  4, 32'hCAFEF00D, 1'b1};
        vecs[2] = '{8'h50, 16'h0,    32'h0,        32'h0,        0, 0, 0,  1, 32'h4B000000, 1'b0};
        vecs[3] = '{8'h7A, 16'h0,    32'h0,        32'h0,        0, 0, 0,  1, 32'h3F000000, 1'b0};
        vecs[4] = '{8'h52, 16'hFFFF, 32'h0,        32'h00000001, 0, 0, 3,  4, 32'h00000001, 1'b1};
        vecs[5] = '{8'h57, 16'h0000, 32'hFFFFFFFF, 32'h0,        0, 2, 19, 1, 32'h4B000000, 1'b1};
        vecs[6] = '{8'h00, 16'h0,    32'h0,        32'h0,        0, 0, 0,  1, 32'h3F000000, 1'b0};
        vecs[7] = '{8'h52, 16'h8001, 32'h0,        32'h12345678, 1, 1, 0,  4, 32'h12345678, 1'b1};

        rst_in = 1'b0;
        rx_valid_in = 1'b0;
        rx_byte_in = 8'h0;
        #13 check_zero("reset");
        step();
        #2 rst_in = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            ack_delay = vecs[i].ack_dly;
            ready_stall = vecs[i].stall;
            rd_value = vecs[i].rdata;
            for (int k = 0; k < vecs[i].n_resp; k++) tx_q.push_back(vecs[i].resp[31 - 8*k -: 8]);
            if (vecs[i].mem) push_mem(vecs[i].op == 8'h57, vecs[i].addr, vecs[i].wdata);
            send_packet(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].gap);
            wait_idle($sformatf("vec%0d", i));
        end
        check("no_timeout_in_table", 64'(tmo_count), 64'(0));

        // Ping and unknown opcode: response visible one cycle after the opcode.
        ready_stall = 0;
        tx_q.push_back(8'h4B);
        send_byte(8'h50);
        check("ping_lat_valid", 64'(tx_valid_out), 64'(1));
        check("ping_lat_byte", 64'(tx_byte_out), 64'(8'h4B));
        check("ping_no_req", 64'(mem_req_out), 64'(0));
        wait_idle("ping");
        tx_q.push_back(8'h3F);
        send_byte(8'h7A);
        check("unk_lat_byte", 64'({tx_valid_out, tx_byte_out}), 64'({1'b1, 8'h3F}));
        wait_idle("unknown");

        // Read with ack in the first request cycle.
        ack_delay = 0;
        rd_value = 32'h11223344;
        push_mem(1'b0, 16'h0001, 32'h0);
        for (int k = 0; k < 4; k++) tx_q.push_back(rd_value[31 - 8*k -: 8]);
        send_packet(8'h52, 16'h0001, 32'h0, 0);
        check("rd_req_rise", 64'(mem_req_out), 64'(1));
        step();
        check("rd_first_byte", 64'({tx_valid_out, tx_byte_out}), 64'({1'b1, 8'h11}));
        wait_idle("read_fast");

        // Timeout after a partial write packet.
        base = tmo_count;
        send_byte(8'h57);
        send_byte(8'h12);
        repeat (T - 1) step();
        check("tmo_before_busy", 64'({busy_out, timeout_err_out}), 64'({1'b1, 1'b0}));
        step();
        check("tmo_fire", 64'({busy_out, timeout_err_out, mem_req_out}), 64'({1'b0, 1'b1, 1'b0}));
        step();
        check("tmo_pulse_end", 64'(timeout_err_out), 64'(0));
        check("tmo_count_one", 64'(tmo_count - base), 64'(1));
        ping("after_tmo");

        // Byte on the expiry cycle is accepted.
        base = tmo_count;
        ack_delay = 1;
        push_mem(1'b1, 16'h1234, 32'h0BADF00D);
        tx_q.push_back(8'h4B);
        send_byte(8'h57);
        send_byte(8'h12);
        repeat (T - 1) step();
        send_byte(8'h34);
        send_byte(8'h0B);
        send_byte(8'hAD);
        send_byte(8'hF0);
        send_byte(8'h0D);
        wait_idle("tmo_edge");
        check("tmo_edge_none", 64'(tmo_count - base), 64'(0));

        // Bytes dropped during MEM and RESP.
        check("overrun_clear", 64'(overrun_out), 64'(0));
        ack_delay = 4;
        ready_stall = 3;
        rd_value = 32'hA1B2C3D4;
        push_mem(1'b0, 16'h0042, 32'h0);
        for (int k = 0; k < 4; k++) tx_q.push_back(rd_value[31 - 8*k -: 8]);
        send_packet(8'h52, 16'h0042, 32'h0, 0);
        send_byte(8'h50);
        check("ovr_mem", 64'({overrun_out, mem_req_out}), 64'({1'b1, 1'b1}));
        for (int n = 0; n < 50 && !tx_valid_out; n++) step();
        check("ovr_in_resp", 64'(tx_valid_out), 64'(1));
        send_byte(8'h57);
        wait_idle("overrun");
        repeat (3) step();
        check("ovr_sticky", 64'({overrun_out, busy_out, tx_valid_out}), 64'({1'b1, 1'b0, 1'b0}));

        // Reset mid-packet, during MEM, and during RESP.
        send_byte(8'h57);
        send_byte(8'h12);
        do_reset("rst_addr");
        ack_delay = 1000;
        push_mem(1'b0, 16'h0020, 32'h0);
        send_packet(8'h52, 16'h0020, 32'h0, 0);
        step();
        check("rst_mem_pre", 64'(mem_req_out), 64'(1));
        do_reset("rst_mem");
        ack_delay = 0;
        ready_stall = 1000;
        rd_value = 32'h55AA55AA;
        push_mem(1'b0, 16'h0030, 32'h0);
        for (int k = 0; k < 4; k++) tx_q.push_back(rd_value[31 - 8*k -: 8]);
        send_packet(8'h52, 16'h0030, 32'h0, 0);
        repeat (3) step();
        check("rst_resp_pre", 64'(tx_valid_out), 64'(1));
        do_reset("rst_resp");
        ping("after_rst");

        // Byte arriving in the final RESP cycle is dropped.
        ready_stall = 0;
        tx_q.push_back(8'h4B);
        send_byte(8'h50);
        send_byte(8'h50);
        check("last_cycle_idle", 64'(busy_out), 64'(0));
        wait_idle("last_cycle");
        repeat (3) step();
        check("last_cycle_drop", 64'({overrun_out, tx_valid_out, busy_out}), 64'({1'b1, 1'b0, 1'b0}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_sequencer.md
# uart_cmd_sequencer

Command sequencer for the UART debugger. It consumes the byte stream from the UART receiver, which presents one byte per one-cycle valid pulse. It parses fixed-format read, write and ping packets, issues a single memory transaction per packet over a req/ack handshake, and sequences the response bytes into the UART transmitter over a valid/ready handshake. It sits between the UART receiver and transmitter and the debug memory port, and is the only master of that port.

## Interface
Parameters:
- ADDR_BYTES, 2, address bytes per packet; mem_addr_out is 8*ADDR_BYTES bits wide.
- DATA_BYTES, 4, data bytes per packet; mem_wdata_out and mem_rdata_in are 8*DATA_BYTES bits wide.
- TIMEOUT_CYCLES, 1_000_000, idle cycles allowed between bytes inside a packet.

Ports:
- clk_in  input  1  system clock; all logic runs on its rising edge.
- rst_in  input  1  asynchronous, active-low reset (0 = reset).
- rx_valid_in  input  1  one-cycle pulse: rx_byte_in is valid.
- rx_byte_in  input  8  received byte.
- mem_req_out  output  1  memory request; held until acknowledged.
- mem_we_out  output  1  1 = write, 0 = read; valid while mem_req_out is high.
- mem_addr_out  output  8*ADDR_BYTES  transaction address.
- mem_wdata_out  output  8*DATA_BYTES  write data.
- mem_ack_in  input  1  one-cycle acknowledge; on reads, mem_rdata_in is valid in the same cycle.
- mem_rdata_in  input  8*DATA_BYTES  read data.
- tx_valid_out  output  1  tx_byte_out is valid.
- tx_byte_out  output  8  response byte.
- tx_ready_in  input  1  transmitter accepts the byte when tx_valid_out and tx_ready_in are both high.
- busy_out  output  1  state is not IDLE.
- timeout_err_out  output  1  one-cycle pulse on packet abort due to timeout.
- overrun_out  output  1  sticky: a byte was dropped while busy.

## Operation
- Packet format: opcode, then address bytes MSB first; write packets then carry data bytes MSB first.
- Opcodes:
  - 0x57 'W' is write.
  - 0x52 'R' is read.
  - 0x50 'P' is ping, with no address and no data.
- Responses:
  - W: the single byte 0x4B 'K', sent after the memory ack.
  - R: DATA_BYTES read-data bytes, MSB first.
  - P: the single byte 0x4B.
  - Any other opcode: the single byte 0x3F '?', with no memory access.
- States are IDLE, ADDR, DATA, MEM, RESP.
  - IDLE: a byte is accepted as the opcode. W or R goes to ADDR; P or unknown goes to RESP with the 1-byte response loaded.
  - ADDR: address bytes are shifted in from the LSB side. After ADDR_BYTES bytes, W goes to DATA and R goes to MEM.
  - DATA: after DATA_BYTES bytes, go to MEM.
  - MEM: mem_req_out is high. On mem_ack_in, read data is captured into the response shift register and the state goes to RESP.
  - RESP: bytes are presented MSB first. Each accepted transfer advances to the next byte. After the last byte is accepted, go to IDLE.
- Byte counter width is $clog2(max(ADDR_BYTES,DATA_BYTES)+1). It is cleared on every state change.
- Timeout:
  - The counter counts cycles in ADDR and DATA only, and clears on every accepted byte.
  - When it reaches TIMEOUT_CYCLES: go to IDLE, pulse timeout_err_out, send no response and make no memory access.
- Dropping: rx_valid_in in MEM or RESP drops the byte and sets overrun_out. overrun_out clears only on reset.
- mem_ack_in is ignored when mem_req_out is low.
- Reset (asynchronous, any time): state goes to IDLE, all outputs and internal registers go to 0, and an in-flight request or response is abandoned.

## Timing
- All outputs reset to 0.
- The byte is sampled in the rx_valid_in cycle. The state update is visible on the next cycle.
- mem_req_out rises the cycle after the last packet byte is accepted. mem_addr_out, mem_we_out and mem_wdata_out are stable from that cycle until the ack.
- mem_req_out falls the cycle after the mem_ack_in cycle.
- An ack in the first request cycle is legal, giving a minimum MEM dwell of one cycle.
- tx_valid_out rises the cycle after the ack, or the cycle after the opcode for P and unknown opcodes.
- tx_byte_out is stable while tx_valid_out is high and tx_ready_in is low. The next byte appears the cycle after a transfer, giving back-to-back transfers when tx_ready_in stays high.
- tx_valid_out falls the cycle after the final transfer. The next opcode is accepted from that cycle.
- Minimum latency, opcode to first response byte:
  - ping: 1 cycle.
  - read: ADDR_BYTES byte gaps, then 1 cycle, then the ack wait, then 1 cycle.
- Simultaneous events:
  - A byte arriving in the same cycle the timeout would expire is accepted; the timeout does not fire.
  - A byte arriving in the cycle RESP returns to IDLE is dropped and sets overrun_out.

## Test plan
- Write: send 57 12 34 DE AD BE EF and ack after 3 cycles. Expect mem_addr_out=0x1234, mem_wdata_out=0xDEADBEEF, mem_we_out=1 held until the ack. Then tx sends 0x4B, then IDLE.
- Read: send 52 00 10, return mem_rdata_in=0xCAFEF00D on the ack, and hold tx_ready_in low for 5 cycles per byte. Expect tx bytes CA FE F0 0D, each stable while not ready.
- Ping and unknown: send 50, expect 0x4B one cycle later with no mem_req_out. Send 7A, expect 0x3F with no mem_req_out.
- Timeout: use TIMEOUT_CYCLES=20 and send 57 12, then stop. Expect timeout_err_out pulsed once, IDLE, no mem_req_out. A following ping responds normally. Repeat with the next byte arriving exactly on the expiry cycle: expect no timeout.
- Overrun: send bytes during MEM and during RESP. Expect them dropped, overrun_out=1 and remaining 1, and the response unchanged.
- Reset: assert rst_in low mid-packet, during MEM, and during RESP. Expect all outputs 0 immediately, then a clean ping response after release.
